// File: rtl/bcp_clause_scheduler.sv
// bcp_clause_scheduler: issues one BCP pass of clause reads, queues implications, stops on first conflict
module bcp_clause_scheduler #(
  parameter int NUM_CLAUSES = 1023,
  parameter int ADDR_W      = 10,
  parameter int VAR_W       = 9,
  parameter int IMPL_DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              conflict,
  output logic [ADDR_W-1:0] conflict_clause,
  output logic              clause_rd_en,
  output logic [ADDR_W-1:0] clause_rd_addr,
  input  logic              eval_valid,
  input  logic              eval_sat,
  input  logic              eval_open,
  input  logic              eval_unit,
  input  logic [VAR_W-1:0]  eval_var,
  input  logic              eval_val,
  output logic              impl_valid,
  output logic [VAR_W-1:0]  impl_var,
  output logic              impl_val,
  input  logic              impl_ready,
  output logic [ADDR_W-1:0] impl_count
);
  localparam int PW = $clog2(IMPL_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_CLAUSES - 1);
  localparam logic [CW-1:0] DEPTH = CW'(IMPL_DEPTH);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;
  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_ptr, r_fl_addr, r_conf_idx, r_impl_cnt;
  logic              r_inflight, r_conflict;
  logic [VAR_W:0]    r_mem [IMPL_DEPTH];
  logic [PW-1:0]     r_wp, r_rp;
  logic [CW-1:0]     r_occ;
  logic              w_active, w_accept, w_issue, w_ev, w_conf, w_push, w_pop;
  always_comb begin
    w_active = (r_state == SCAN) || (r_state == DRAIN);
    w_accept = (r_state == IDLE) && start;
    // the in-flight read reserves a FIFO slot so a push can never overflow
    w_issue  = (r_state == SCAN) && ((r_occ + CW'(r_inflight)) < DEPTH);
    w_ev     = w_active && r_inflight && eval_valid;
    w_conf   = w_ev && !eval_sat && !eval_open;
    w_push   = w_ev && !eval_sat && eval_open && eval_unit;
    w_pop    = (r_occ != '0) && impl_ready;
    w_next   = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? SCAN : IDLE;
      SCAN:    w_next = w_conf ? DONE : (w_issue && r_ptr == LAST) ? DRAIN : SCAN;
      DRAIN:   w_next = w_ev ? DONE : DRAIN;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_fl_addr  <= '0;
      r_inflight <= 1'b0;
      r_conflict <= 1'b0;
      r_conf_idx <= '0;
      r_impl_cnt <= '0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_occ      <= '0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_issue;
      if (w_accept) r_ptr <= '0;
      else if (w_issue) r_ptr <= r_ptr + ADDR_W'(1);
      if (w_issue) r_fl_addr <= r_ptr;
      if (w_accept) begin
        r_conflict <= 1'b0;
        r_conf_idx <= '0;
        r_impl_cnt <= '0;
      end else begin
        if (w_conf) begin
          r_conflict <= 1'b1;
          r_conf_idx <= r_fl_addr;
        end
        if (w_push && r_impl_cnt != '1) r_impl_cnt <= r_impl_cnt + ADDR_W'(1);
      end
      if (w_push) r_wp <= r_wp + PW'(1);
      if (w_pop) r_rp <= r_rp + PW'(1);
      r_occ <= r_occ + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= {eval_var, eval_val};
  end
  assert property (@(posedge clk) disable iff (!rst_n) !(w_push && !w_pop && r_occ == DEPTH));
  assign busy            = w_active;
  assign done            = (r_state == DONE);
  assign conflict        = r_conflict;
  assign conflict_clause = r_conf_idx;
  assign clause_rd_en    = w_issue;
  assign clause_rd_addr  = r_ptr;
  assign impl_valid      = (r_occ != '0);
  assign {impl_var, impl_val} = r_mem[r_rp];
  assign impl_count      = r_impl_cnt;
endmodule
